// File: rtl/sm83_irq_ctl_if.sv
// Interrupt controller bus: peripheral request lines, IF/IE register access,
// IME control strobes and the dispatch handshake with the control unit.
interface sm83_irq_ctl_if #(
    parameter int NUM_IRQS = 8
);
    logic [NUM_IRQS-1:0] irq_in;
    logic [NUM_IRQS-1:0] wdata;
    logic                if_we;
    logic                ie_we;
    logic [NUM_IRQS-1:0] if_q;
    logic [NUM_IRQS-1:0] ie_q;
    logic                ei;
    logic                di;
    logic                reti;
    logic                instr_done;
    logic                int_req;
    logic                wake;
    logic                int_ack;
    logic                vec_sample;
    logic [15:0]         vec;
    logic                vec_valid;
    logic [NUM_IRQS-1:0] iack;
    logic                ime_q;

    modport master (
        output irq_in, wdata, if_we, ie_we, ei, di, reti, instr_done, int_ack, vec_sample,
        input  if_q, ie_q, int_req, wake, vec, vec_valid, iack, ime_q
    );

    modport slave (
        input  irq_in, wdata, if_we, ie_we, ei, di, reti, instr_done, int_ack, vec_sample,
        output if_q, ie_q, int_req, wake, vec, vec_valid, iack, ime_q
    );
endinterface

// File: rtl/sm83_irq_ctl.sv
// sm83 interrupt controller: edge-latched IF, IE masking, IME with delayed EI,
// HALT wake and a late-sampled dispatch handshake with fixed or round-robin priority.
module sm83_irq_ctl #(
    parameter int          NUM_IRQS   = 8,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int          VEC_STRIDE = 8,
    parameter int          EI_DELAY   = 1,
    parameter int          PRIO_MODE  = 0
) (
    input  logic          clk,
    input  logic          n_reset,
    sm83_irq_ctl_if.slave bus
);
    localparam int IDX_W = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACKED,
        DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [NUM_IRQS-1:0] if_r;
    logic [NUM_IRQS-1:0] ie_r;
    logic [NUM_IRQS-1:0] prev_irq;
    logic [NUM_IRQS-1:0] irq_edge;
    logic [NUM_IRQS-1:0] pend;
    logic [NUM_IRQS-1:0] dispatch_clr;
    logic [NUM_IRQS-1:0] iack_r;
    logic [IDX_W-1:0]    rr_ptr;
    logic [15:0]         vec_r;
    logic [15:0]         vec_calc;
    logic                ime;
    logic                ei_pend;
    logic [1:0]          ei_cnt;
    logic                ei_expire;
    logic                int_req;
    logic                ack_take;
    logic                sample_take;
    logic                has_win;
    int                  win_idx;
    int                  best_dist;
    int                  search_base;

    assign irq_edge    = bus.irq_in & ~prev_irq;
    assign pend        = if_r & ie_r;
    assign int_req     = ime & (|pend);
    assign search_base = (PRIO_MODE == 1) ? int'(rr_ptr) : 0;

    // Winner is the pending line closest to search_base, walking upward with wrap.
    always_comb begin
        has_win   = 1'b0;
        win_idx   = 0;
        best_dist = NUM_IRQS;
        for (int j = 0; j < NUM_IRQS; j++) begin
            if (pend[j] && (((j - search_base + NUM_IRQS) % NUM_IRQS) < best_dist)) begin
                has_win   = 1'b1;
                win_idx   = j;
                best_dist = (j - search_base + NUM_IRQS) % NUM_IRQS;
            end
        end
    end

    assign vec_calc     = VEC_BASE + 16'(win_idx) * 16'(VEC_STRIDE);
    assign dispatch_clr = (sample_take && has_win) ? (NUM_IRQS'(1) << win_idx) : '0;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        ack_take    = 1'b0;
        sample_take = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.int_ack && int_req) begin
                    ack_take   = 1'b1;
                    next_state = ACKED;
                end
            end
            ACKED: begin
                if (bus.vec_sample) begin
                    sample_take = 1'b1;
                    next_state  = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Edge-detect history resets high so a line already asserted at release is not an edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            if_r     <= '0;
            ie_r     <= '0;
            prev_irq <= '1;
            iack_r   <= '0;
            vec_r    <= '0;
            rr_ptr   <= '0;
        end else begin
            prev_irq <= bus.irq_in;
            if_r     <= ((bus.if_we ? bus.wdata : if_r) | irq_edge) & ~dispatch_clr;
            if (bus.ie_we) begin
                ie_r <= bus.wdata;
            end
            iack_r <= dispatch_clr;
            if (sample_take) begin
                vec_r <= has_win ? vec_calc : 16'h0000;
                if (has_win) begin
                    rr_ptr <= IDX_W'((win_idx + 1) % NUM_IRQS);
                end
            end
        end
    end

    assign ei_expire = (ei_pend && bus.instr_done && (ei_cnt == 2'd1)) ||
                       (!ei_pend && bus.ei && (EI_DELAY == 0));

    // DI and an accepted dispatch both drop IME and abandon a pending EI.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ime     <= 1'b0;
            ei_pend <= 1'b0;
            ei_cnt  <= 2'd0;
        end else if (bus.di || ack_take) begin
            ime     <= 1'b0;
            ei_pend <= 1'b0;
            ei_cnt  <= 2'd0;
        end else begin
            if (bus.reti || ei_expire) begin
                ime <= 1'b1;
            end
            if (ei_pend) begin
                if (bus.instr_done) begin
                    ei_cnt <= ei_cnt - 2'd1;
                    if (ei_cnt == 2'd1) begin
                        ei_pend <= 1'b0;
                    end
                end
            end else if (bus.ei && (EI_DELAY != 0)) begin
                ei_pend <= 1'b1;
                ei_cnt  <= 2'(EI_DELAY);
            end
        end
    end

    assign bus.if_q      = if_r;
    assign bus.ie_q      = ie_r;
    assign bus.ime_q     = ime;
    assign bus.int_req   = int_req;
    assign bus.wake      = |pend;
    assign bus.vec       = vec_r;
    assign bus.vec_valid = (state == DONE);
    assign bus.iack      = iack_r;
endmodule
